buffer_b_bank: RTL and testbench
================================

// Module: buffer_b_bank
// PURPOSE
//  Parametrised multi-bank store for MMU operand B. Loads a dim_x x dim_y matrix one
//  word per accepted beat (column-major), then streams it back one MMU row per cycle
//  toward the systolic array. Adds over the previous generation: NUM_BUF banks,
//  an input valid handshake, registered output with b1_valid, busy/done/err
//  status, and command validation.
// PARAMETERS
//  VAR_SIZE  8   element width, bits (signed)
//  MMU_SIZE  10  array edge; max rows/cols per matrix
//  NUM_BUF   16  number of independent banks
//  DIM_W     8   width of dimension fields
//  BUF_W     $clog2(NUM_BUF) (min 1) bank-index width, derived
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst_n      in   1                  reset, synchronous, active-low
//  cmd        in   2                  00 NONE, 01 LOAD, 10 SEND, 11 CLEAR
//  buffer     in   BUF_W              target bank for cmd; selects dim_*_out
//  dim_x_in   in   DIM_W              rows of matrix (LOAD only)
//  dim_y_in   in   DIM_W              cols of matrix (LOAD only)
//  A          in   VAR_SIZE           load data word (signed)
//  a_valid    in   1                  A valid this cycle (LOAD state)
//  stop       in   1                  freeze pointers; with cmd=CLEAR aborts to CLEAR
//  B1         out  VAR_SIZE*MMU_SIZE  one row; col j at [j*VAR_SIZE +: VAR_SIZE]
//  b1_valid   out  1                  B1 holds a valid row
//  busy       out  1                  state != IDLE
//  done       out  1                  1-cycle pulse: LOAD/SEND/CLEAR completed
//  err        out  1                  1-cycle pulse: command rejected
//  dim_x_out  out  DIM_W              stored dim_x of bank `buffer`, registered
//  dim_y_out  out  DIM_W              stored dim_y of bank `buffer`, registered
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, pointers 0, all bank dims 0, B1=0,
//   b1_valid=0, done=0, err=0, dim_*_out=0. Data RAM is not reset. Reset mid-op
//   aborts the op at that edge; partially loaded data remains but dims read 0.
//  FSM IDLE/LOAD/SEND/CLEAR. In IDLE with stop=0, cmd!=NONE is sampled, bank latched.
//  Rejects (err pulse next cycle, stay IDLE): buffer>=NUM_BUF; LOAD with dim_x_in or
//   dim_y_in equal to 0 or >MMU_SIZE; SEND of a bank whose stored dim_x==0.
//  LOAD: bank dims <= dim_*_in on acceptance. Each cycle with a_valid=1 and stop=0
//   writes A to (row,col); row++ until dim_x-1, then row=0, col++. The word at
//   (dim_x-1,dim_y-1) ends LOAD: IDLE next edge, done pulse. a_valid=0: no write.
//  SEND: row r=0..dim_x-1, one per cycle unless stop. B1/b1_valid registered: row r
//   appears one cycle after it is addressed; first row one cycle after entering
//   SEND. Columns >= stored dim_y and rows never written since CLEAR read 0.
//   stop=1: pointer holds, B1 holds last row, b1_valid=0. After last row: IDLE,
//   done pulse in the same cycle as the last b1_valid; B1=0 the following cycle.
//  CLEAR: zero one row per cycle, MMU_SIZE cycles, bank dims <= 0; then IDLE, done.
//   stop=1 with cmd=CLEAR in LOAD/SEND: abort, enter CLEAR on the current bank.
//  stop=1 in IDLE: commands ignored. cmd ignored while busy (except abort above).
//  dim_*_out: one-cycle-registered view of bank `buffer`; a LOAD/CLEAR updating
//   the same bank is visible on dim_*_out two cycles after acceptance.
//  Pointers width DIM_W; no wrap: dims bounded by MMU_SIZE validation.
// TESTING
//  1. LOAD bank 3, 3x2, A=1..6 on consecutive a_valid -> done after 6th word;
//     SEND bank 3 -> 3 rows {1,4},{2,5},{3,6}, cols 2..9 = 0, b1_valid 3 cycles.
//  2. LOAD with a_valid toggling 1/0 -> only valid beats stored; done after 6th.
//  3. SEND 4x4 with stop high for 2 cycles at row 1 -> row 1 held, b1_valid low,
//     rows 2,3 follow; total 4 valid rows, values intact.
//  4. LOAD dim_x_in=11 (MMU_SIZE=10) or buffer=NUM_BUF -> err pulse, busy stays 0,
//     dims unchanged; SEND of empty bank -> err.
//  5. stop+CLEAR mid-LOAD bank 2 -> CLEAR 10 cycles, done; dim_*_out(2)=0; SEND err.
//  6. Reset asserted mid-SEND -> next cycle B1=0, b1_valid=0, busy=0, dims 0.

Source files
------------

// File: rtl/buffer_b_bank.sv
// Multi-bank operand-B store for the MMU: column-major matrix load, row-per-cycle
// streaming to the systolic array, bank clear, and command validation.
module buffer_b_bank #(
  parameter int VAR_SIZE = 8,
  parameter int MMU_SIZE = 10,
  parameter int NUM_BUF  = 16,
  parameter int DIM_W    = 8,
  parameter int BUF_W    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   cmd,
  input  logic [BUF_W-1:0]             buffer,
  input  logic [DIM_W-1:0]             dim_x_in,
  input  logic [DIM_W-1:0]             dim_y_in,
  input  logic [VAR_SIZE-1:0]          A,
  input  logic                         a_valid,
  input  logic                         stop,
  output logic [VAR_SIZE*MMU_SIZE-1:0] B1,
  output logic                         b1_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [DIM_W-1:0]             dim_x_out,
  output logic [DIM_W-1:0]             dim_y_out
);

  localparam int IDX_W = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
  localparam logic [DIM_W-1:0] MMU_D = DIM_W'(MMU_SIZE);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_SEND  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]          state;
  logic [BUF_W-1:0]    bank_q;
  logic [DIM_W-1:0]    row_ptr;
  logic [DIM_W-1:0]    col_ptr;
  logic [DIM_W-1:0]    dim_x_mem [NUM_BUF];
  logic [DIM_W-1:0]    dim_y_mem [NUM_BUF];
  logic [VAR_SIZE-1:0] mem [NUM_BUF][MMU_SIZE][MMU_SIZE];

  logic                         bank_ok;
  logic [BUF_W-1:0]             buf_idx;
  logic [DIM_W-1:0]             cur_dx;
  logic [DIM_W-1:0]             cur_dy;
  logic                         last_row;
  logic                         last_col;
  logic                         abort;
  logic                         load_dims_bad;
  logic                         ram_we;
  logic                         clr_we;
  logic [IDX_W-1:0]             row_idx;
  logic [IDX_W-1:0]             col_idx;
  logic [VAR_SIZE*MMU_SIZE-1:0] row_data;

  assign bank_ok       = (int'(buffer) < NUM_BUF);
  assign buf_idx       = bank_ok ? buffer : '0;
  assign cur_dx        = dim_x_mem[bank_q];
  assign cur_dy        = dim_y_mem[bank_q];
  assign last_row      = (row_ptr == cur_dx - DIM_W'(1));
  assign last_col      = (col_ptr == cur_dy - DIM_W'(1));
  assign abort         = stop && (cmd == CMD_CLEAR);
  assign load_dims_bad = (dim_x_in == '0) || (dim_x_in > MMU_D) ||
                         (dim_y_in == '0) || (dim_y_in > MMU_D);
  assign row_idx       = row_ptr[IDX_W-1:0];
  assign col_idx       = col_ptr[IDX_W-1:0];
  assign busy          = (state != S_IDLE);

  // Writes are gated by rst_n so a reset edge aborts an in-flight load/clear.
  assign ram_we = rst_n && (state == S_LOAD)  && !stop && a_valid;
  assign clr_we = rst_n && (state == S_CLEAR) && !stop;

  // Columns beyond the stored width are masked so stale data never leaks out.
  always_comb begin
    // NOTE: default first so every path assigns row_data and no latch is inferred.
    row_data = '0;
    for (int j = 0; j < MMU_SIZE; j++) begin
      if (j < int'(cur_dy)) row_data[j*VAR_SIZE +: VAR_SIZE] = mem[bank_q][row_idx][j];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the data RAM is intentionally not reset; zeroed dims make it unreadable.
    if (ram_we) begin
      mem[bank_q][row_idx][col_idx] <= A;
    end else if (clr_we) begin
      for (int c = 0; c < MMU_SIZE; c++) mem[bank_q][row_idx][c] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bank_q    <= '0;
      row_ptr   <= '0;
      col_ptr   <= '0;
      B1        <= '0;
      b1_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dim_x_out <= '0;
      dim_y_out <= '0;
      for (int b = 0; b < NUM_BUF; b++) begin
        dim_x_mem[b] <= '0;
        dim_y_mem[b] <= '0;
      end
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      dim_x_out <= bank_ok ? dim_x_mem[buf_idx] : '0;
      dim_y_out <= bank_ok ? dim_y_mem[buf_idx] : '0;

      case (state)
        S_IDLE: begin
          B1       <= '0;
          b1_valid <= 1'b0;
          if (!stop && cmd != CMD_NONE) begin
            row_ptr <= '0;
            col_ptr <= '0;
            bank_q  <= buf_idx;
            if (!bank_ok) begin
              err <= 1'b1;
            end else begin
              case (cmd)
                CMD_LOAD: begin
                  if (load_dims_bad) begin
                    err <= 1'b1;
                  end else begin
                    dim_x_mem[buf_idx] <= dim_x_in;
                    dim_y_mem[buf_idx] <= dim_y_in;
                    state              <= S_LOAD;
                  end
                end
                CMD_SEND: begin
                  if (dim_x_mem[buf_idx] == '0) err <= 1'b1;
                  else                          state <= S_SEND;
                end
                default: begin
                  dim_x_mem[buf_idx] <= '0;
                  dim_y_mem[buf_idx] <= '0;
                  state              <= S_CLEAR;
                end
              endcase
            end
          end
        end

        S_LOAD: begin
          if (abort) begin
            dim_x_mem[bank_q] <= '0;
            dim_y_mem[bank_q] <= '0;
            row_ptr           <= '0;
            col_ptr           <= '0;
            state             <= S_CLEAR;
          end else if (!stop && a_valid) begin
            if (last_row) begin
              row_ptr <= '0;
              if (last_col) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                col_ptr <= col_ptr + 1'b1;
              end
            end else begin
              row_ptr <= row_ptr + 1'b1;
            end
          end
        end

        S_SEND: begin
          if (abort) begin
            dim_x_mem[bank_q] <= '0;
            dim_y_mem[bank_q] <= '0;
            row_ptr           <= '0;
            col_ptr           <= '0;
            B1                <= '0;
            b1_valid          <= 1'b0;
            state             <= S_CLEAR;
          end else if (stop) begin
            b1_valid <= 1'b0;
          end else begin
            B1       <= row_data;
            b1_valid <= 1'b1;
            if (last_row) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              row_ptr <= row_ptr + 1'b1;
            end
          end
        end

        default: begin
          if (!stop) begin
            if (row_ptr == MMU_D - DIM_W'(1)) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              row_ptr <= row_ptr + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_b_bank.sv
// Self-checking bench for buffer_b_bank: directed corner sequences, a reject-vector
// table, and randomized load/send traffic checked against a per-bank matrix model.
module tb_buffer_b_bank;

  localparam int VS = 8;
  localparam int MS = 10;
  localparam int NB = 12;
  localparam int DW = 8;
  localparam int BW = 4;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_SEND  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cmd;
  logic [BW-1:0] buffer;
  logic [DW-1:0] dim_x_in, dim_y_in;
  logic [VS-1:0] A;
  logic          a_valid, stop;
  logic [VS*MS-1:0] B1;
  logic          b1_valid, busy, done, err;
  logic [DW-1:0] dim_x_out, dim_y_out;

  buffer_b_bank #(.VAR_SIZE(VS), .MMU_SIZE(MS), .NUM_BUF(NB), .DIM_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .buffer(buffer),
    .dim_x_in(dim_x_in), .dim_y_in(dim_y_in), .A(A), .a_valid(a_valid),
    .stop(stop), .B1(B1), .b1_valid(b1_valid), .busy(busy), .done(done),
    .err(err), .dim_x_out(dim_x_out), .dim_y_out(dim_y_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: each bank is a plain matrix plus its stored dimensions.
  logic [VS-1:0] mdl [NB][MS][MS];
  int mdx [NB];
  int mdy [NB];

  typedef struct {
    logic [1:0] cmd;
    int         buffer;
    int         dx;
    int         dy;
    logic       stop;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VS*MS-1:0] exp_row(input int b, input int r);
    logic [VS*MS-1:0] v;
    v = '0;
    for (int j = 0; j < mdy[b]; j++) v[j*VS +: VS] = mdl[b][r][j];
    return v;
  endfunction

  // gap_mode: 0 back-to-back, 1 idle beat between words, 2 random idle beats.
  task automatic do_load(input int b, input int dx, input int dy, input int gap_mode, input int base);
    logic [VS-1:0] w;
    cmd = C_LOAD; buffer = BW'(b); dim_x_in = DW'(dx); dim_y_in = DW'(dy);
    tick();
    cmd = C_NONE;
    check("load_accept_busy", busy, 1'b1);
    check("load_accept_err", err, 1'b0);
    mdx[b] = dx;
    mdy[b] = dy;
    for (int k = 0; k < dx * dy; k++) begin
      if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        a_valid = 1'b0; A = VS'($urandom);
        tick();
        check("load_gap_no_done", done, 1'b0);
      end
      w = (gap_mode == 2) ? VS'($urandom) : VS'(base + k);
      a_valid = 1'b1; A = w;
      mdl[b][k % dx][k / dx] = w;
      tick();
      check("load_done", done, (k == dx * dy - 1));
    end
    a_valid = 1'b0;
    check("load_end_busy", busy, 1'b0);
    tick();
    check("load_done_pulse", done, 1'b0);
    check("load_dim_x_out", dim_x_out, DW'(dx));
    check("load_dim_y_out", dim_y_out, DW'(dy));
  endtask

  task automatic do_send(input int b, input int stop_after, input int stop_len);
    cmd = C_SEND; buffer = BW'(b);
    tick();
    cmd = C_NONE;
    check("send_accept_busy", busy, 1'b1);
    check("send_first_gap", b1_valid, 1'b0);
    for (int r = 0; r < mdx[b]; r++) begin
      stop = 1'b0;
      tick();
      check("send_row", B1, exp_row(b, r));
      check("send_valid", b1_valid, 1'b1);
      check("send_done", done, (r == mdx[b] - 1));
      if (r == stop_after) begin
        for (int s = 0; s < stop_len; s++) begin
          stop = 1'b1;
          tick();
          check("stop_valid_low", b1_valid, 1'b0);
          check("stop_row_held", B1, exp_row(b, r));
        end
        stop = 1'b0;
      end
    end
    tick();
    check("send_tail_B1", B1, '0);
    check("send_tail_valid", b1_valid, 1'b0);
    check("send_tail_busy", busy, 1'b0);
  endtask

  task automatic expect_err(input string name, input logic [1:0] c, input int b);
    cmd = c; buffer = BW'(b);
    tick();
    cmd = C_NONE;
    check(name, err, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd = C_NONE; buffer = '0; dim_x_in = '0; dim_y_in = '0;
    A = '0; a_valid = 1'b0; stop = 1'b0;
    for (int b = 0; b < NB; b++) begin mdx[b] = 0; mdy[b] = 0; end
    tick(); tick();
    check("rst_B1", B1, '0);
    check("rst_valid", b1_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dim_x_out", dim_x_out, '0);
    rst_n = 1'b1;
    tick();

    // 1: bank 3, 3x2, words 1..6 back to back.
    do_load(3, 3, 2, 0, 1);
    do_send(3, -1, 0);
    check("t1_row0_literal", exp_row(3, 0), {{8{8'd0}}, 8'd4, 8'd1});

    // 2: bank 5, a_valid toggling.
    do_load(5, 3, 2, 1, 10);
    do_send(5, -1, 0);

    // 3: bank 7, 4x4, stop for 2 cycles after row 1.
    do_load(7, 4, 4, 0, 40);
    do_send(7, 1, 2);

    // 4: rejected and ignored commands from a table.
    vecs.push_back('{C_LOAD,  NB, 2,  2,  1'b0, 1'b1});
    vecs.push_back('{C_LOAD,  3,  11, 2,  1'b0, 1'b1});
    vecs.push_back('{C_LOAD,  3,  2,  11, 1'b0, 1'b1});
    vecs.push_back('{C_LOAD,  3,  0,  2,  1'b0, 1'b1});
    vecs.push_back('{C_LOAD,  3,  2,  0,  1'b0, 1'b1});
    vecs.push_back('{C_SEND,  0,  0,  0,  1'b0, 1'b1});
    vecs.push_back('{C_SEND,  NB, 0,  0,  1'b0, 1'b1});
    vecs.push_back('{C_CLEAR, 15, 0,  0,  1'b0, 1'b1});
    vecs.push_back('{C_LOAD,  3,  2,  2,  1'b1, 1'b0});
    vecs.push_back('{C_NONE,  3,  0,  0,  1'b0, 1'b0});
    foreach (vecs[i]) begin
      cmd = vecs[i].cmd; buffer = BW'(vecs[i].buffer);
      dim_x_in = DW'(vecs[i].dx); dim_y_in = DW'(vecs[i].dy); stop = vecs[i].stop;
      tick();
      cmd = C_NONE; stop = 1'b0;
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      tick();
      check($sformatf("vec%0d_err_pulse", i), err, 1'b0);
    end
    buffer = 4'd3;
    tick(); tick();
    check("rej_dims_x_kept", dim_x_out, DW'(3));
    check("rej_dims_y_kept", dim_y_out, DW'(2));
    do_send(3, -1, 0);

    // 5: abort mid-LOAD on bank 2 with stop+CLEAR.
    cmd = C_LOAD; buffer = 4'd2; dim_x_in = 8'd4; dim_y_in = 8'd4;
    tick();
    cmd = C_NONE;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; A = VS'(k + 100);
      tick();
    end
    a_valid = 1'b0; stop = 1'b1; cmd = C_CLEAR;
    tick();
    stop = 1'b0; cmd = C_NONE;
    check("abort_busy", busy, 1'b1);
    n = 0;
    while (!done && n < 30) begin tick(); n++; end
    check("abort_clear_cycles", n, 10);
    check("abort_idle", busy, 1'b0);
    mdx[2] = 0; mdy[2] = 0;
    tick();
    check("abort_dim_x_out", dim_x_out, '0);
    check("abort_dim_y_out", dim_y_out, '0);
    expect_err("abort_send_err", C_SEND, 2);

    // Plain CLEAR on bank 5.
    cmd = C_CLEAR; buffer = 4'd5;
    tick();
    cmd = C_NONE;
    n = 0;
    while (!done && n < 30) begin tick(); n++; end
    check("clear_cycles", n, 10);
    mdx[5] = 0; mdy[5] = 0;
    expect_err("clear_send_err", C_SEND, 5);

    // 6: reset in the middle of a SEND.
    do_load(4, 2, 3, 0, 60);
    cmd = C_SEND; buffer = 4'd4;
    tick();
    cmd = C_NONE;
    tick();
    check("rst_mid_first_row", b1_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_B1", B1, '0);
    check("rst_mid_valid", b1_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_dim_x", dim_x_out, '0);
    rst_n = 1'b1;
    for (int b = 0; b < NB; b++) begin mdx[b] = 0; mdy[b] = 0; end
    tick();
    expect_err("rst_send_err", C_SEND, 4);

    // Randomized traffic against the model.
    for (int it = 0; it < 8; it++) begin
      int b, dx, dy;
      b  = $urandom_range(0, NB - 1);
      dx = $urandom_range(1, MS);
      dy = $urandom_range(1, MS);
      do_load(b, dx, dy, 2, 0);
      do_send(b, (dx > 1) ? $urandom_range(0, dx - 2) : -1, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
